regfile_dump_reader: RTL and testbench

//  Debug/readback engine: the reader side of the 32x32 register file.
//  - On a start pulse, walks the register file over a spare combinational read port.
//  - Streams each {address, data} pair out over a valid/ready interface (to UART/trace logic).
//  - Replaces simulation-only $display dumps with a synthesizable path.
//  - Sits beside the register file; shares only its read port; never writes.

---
 rtl/regfile_dump_reader.sv | 174 +++++++++++++++++
 tb/tb_regfile_dump_reader.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks a register file read port and streams {addr, data} pairs
//
// Purpose
//    Readback engine for the 32x32 register file. A start pulse walks the
//    address range FIRST_ADDR..LAST_ADDR over a spare combinational read port
//    and presents each register as an {address, data} word on a valid/ready
//    stream. The block never writes the register file.
//
// Ports
//    clk         in   1         clock, all state on rising edge
//    rst_n       in   1         asynchronous active-low reset
//    start       in   1         one-cycle request to begin a dump
//    abort       in   1         cancel a dump in progress
//    rd_addr     out  ADDR_W    register file read address
//    rd_data     in   DATA_W    register file read data (combinational)
//    dump_valid  out  1         dump_addr/dump_data valid
//    dump_ready  in   1         consumer accepts when valid & ready at posedge
//    dump_addr   out  ADDR_W    address of the emitted register
//    dump_data   out  DATA_W    value of the emitted register
//    busy        out  1         dump in progress
//    done        out  1         one-cycle pulse when the full range was walked
//    sent_count  out  ADDR_W+1  words accepted in the current/last dump

module regfile_dump_reader #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int FIRST_ADDR = 0,
   parameter int LAST_ADDR  = 31,
   parameter int SKIP_ZERO  = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [ADDR_W-1:0] dump_addr,
   output logic [DATA_W-1:0] dump_data,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   sent_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_READ = 2'd1;
   localparam logic [1:0] S_SEND = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_ADDR);
   localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);
   localparam logic              SKIP_Z  = (SKIP_ZERO != 0);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              dump_valid_q, dump_valid_d;
   logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
   logic [DATA_W-1:0] dump_data_q, dump_data_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [ADDR_W:0]   sent_count_q, sent_count_d;

   // Equality compare against LAST_A keeps the walk from ever incrementing
   // past the top of the range, so LAST_ADDR = 2**ADDR_W-1 cannot wrap.
   logic at_last;
   assign at_last = (rd_addr_q == LAST_A);

   always_comb begin
      state_d      = state_q;
      rd_addr_d    = rd_addr_q;
      dump_valid_d = dump_valid_q;
      dump_addr_d  = dump_addr_q;
      dump_data_d  = dump_data_q;
      busy_d       = busy_q;
      sent_count_d = sent_count_q;

      case (state_q)
         S_IDLE: begin
            // abort has priority over a simultaneous start
            if (start && !abort) begin
               state_d      = S_READ;
               rd_addr_d    = FIRST_A;
               sent_count_d = '0;
               busy_d       = 1'b1;
            end
         end

         S_READ: begin
            if (abort) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else if (SKIP_Z && (rd_data == '0)) begin
               if (at_last) begin
                  state_d = S_DONE;
               end else begin
                  rd_addr_d = rd_addr_q + 1'b1;
               end
            end else begin
               // rd_data is sampled at the end of the READ cycle, so a
               // register-file write landing on the negedge is included.
               dump_data_d  = rd_data;
               dump_addr_d  = rd_addr_q;
               dump_valid_d = 1'b1;
               state_d      = S_SEND;
            end
         end

         S_SEND: begin
            // An abort cancels the word even if the consumer is ready in
            // the same cycle; it is not counted as sent.
            if (abort) begin
               state_d      = S_IDLE;
               dump_valid_d = 1'b0;
               busy_d       = 1'b0;
            end else if (dump_ready) begin
               dump_valid_d = 1'b0;
               sent_count_d = sent_count_q + 1'b1;
               if (at_last) begin
                  state_d = S_DONE;
               end else begin
                  rd_addr_d = rd_addr_q + 1'b1;
                  state_d   = S_READ;
               end
            end
         end

         S_DONE: begin
            // DONE always lasts one cycle, so abort here changes nothing.
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d      = S_IDLE;
            dump_valid_d = 1'b0;
            busy_d       = 1'b0;
         end
      endcase

      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         rd_addr_q    <= '0;
         dump_valid_q <= 1'b0;
         dump_addr_q  <= '0;
         dump_data_q  <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         sent_count_q <= '0;
      end else begin
         state_q      <= state_d;
         rd_addr_q    <= rd_addr_d;
         dump_valid_q <= dump_valid_d;
         dump_addr_q  <= dump_addr_d;
         dump_data_q  <= dump_data_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         sent_count_q <= sent_count_d;
      end
   end

   assign rd_addr    = rd_addr_q;
   assign dump_valid = dump_valid_q;
   assign dump_addr  = dump_addr_q;
   assign dump_data  = dump_data_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign sent_count = sent_count_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - self-checking bench for regfile_dump_reader

module tb_regfile_dump_reader;

   localparam int DW = 32;
   localparam int AW = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic [DW-1:0] rf [32];

   int checks   = 0;
   int failures = 0;

   // dut0: full range, no skip
   logic          start0, abort0, ready0;
   logic [AW-1:0] rd_addr0, dump_addr0;
   logic [DW-1:0] rd_data0, dump_data0;
   logic          dump_valid0, busy0, done0;
   logic [AW:0]   sent_count0;
   assign rd_data0 = rf[rd_addr0];

   // dut1: full range, skip zero registers
   logic          start1, abort1, ready1;
   logic [AW-1:0] rd_addr1, dump_addr1;
   logic [DW-1:0] rd_data1, dump_data1;
   logic          dump_valid1, busy1, done1;
   logic [AW:0]   sent_count1;
   assign rd_data1 = rf[rd_addr1];

   // dut2: single-register range
   logic          start2, abort2, ready2;
   logic [AW-1:0] rd_addr2, dump_addr2;
   logic [DW-1:0] rd_data2, dump_data2;
   logic          dump_valid2, busy2, done2;
   logic [AW:0]   sent_count2;
   assign rd_data2 = rf[rd_addr2];

   regfile_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .FIRST_ADDR(0), .LAST_ADDR(31), .SKIP_ZERO(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
      .rd_addr(rd_addr0), .rd_data(rd_data0),
      .dump_valid(dump_valid0), .dump_ready(ready0),
      .dump_addr(dump_addr0), .dump_data(dump_data0),
      .busy(busy0), .done(done0), .sent_count(sent_count0));

   regfile_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .FIRST_ADDR(0), .LAST_ADDR(31), .SKIP_ZERO(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
      .rd_addr(rd_addr1), .rd_data(rd_data1),
      .dump_valid(dump_valid1), .dump_ready(ready1),
      .dump_addr(dump_addr1), .dump_data(dump_data1),
      .busy(busy1), .done(done1), .sent_count(sent_count1));

   regfile_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .FIRST_ADDR(7), .LAST_ADDR(7), .SKIP_ZERO(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
      .rd_addr(rd_addr2), .rd_data(rd_data2),
      .dump_valid(dump_valid2), .dump_ready(ready2),
      .dump_addr(dump_addr2), .dump_data(dump_data2),
      .busy(busy2), .done(done2), .sent_count(sent_count2));

   // Accepted words, sampled mid-cycle (inputs only change just after posedge)
   logic [AW+DW-1:0] rx0[$], rx1[$], rx2[$];
   logic [AW+DW-1:0] expq[$];
   int               exp_cycles;

   always @(negedge clk) begin
      if (dump_valid0 && ready0) rx0.push_back({dump_addr0, dump_data0});
      if (dump_valid1 && ready1) rx1.push_back({dump_addr1, dump_data1});
      if (dump_valid2 && ready2) rx2.push_back({dump_addr2, dump_data2});
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference: the words a dump must produce, and (with ready always high)
   // how many clock edges after start the done pulse appears: one edge per
   // skipped register, two per emitted one.
   function automatic void build_exp(input int first, input int last, input bit skip);
      expq.delete();
      exp_cycles = 0;
      for (int a = first; a <= last; a++) begin
         if (skip && rf[a] == 0) begin
            exp_cycles += 1;
         end else begin
            expq.push_back({AW'(a), rf[a]});
            exp_cycles += 2;
         end
      end
   endfunction

   task automatic cmp_stream(input string tag, input logic [AW+DW-1:0] got[$]);
      int n;
      check({tag, "_len"}, 64'(got.size()), 64'(expq.size()));
      n = (got.size() < expq.size()) ? got.size() : expq.size();
      for (int i = 0; i < n; i++) check({tag, "_word"}, 64'(got[i]), 64'(expq[i]));
   endtask

   logic       lat_addr_ok;
   logic [AW-1:0] lat_addr;
   logic       lat_v0, lat_v1;

   // mode 0: ready=1; 1: ready=1 except 5-cycle stall on word 7;
   // 2: random ready; 3: random ready plus restart attempt and r4 write at word 3
   task automatic run0(input int mode, output int cyc, output bit saw_done);
      int hold = 0;
      bit hooked = 0;
      rx0.delete();
      start0 = 1'b1;
      ready0 = (mode >= 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      tick;
      start0   = 1'b0;
      lat_addr = rd_addr0;
      lat_v0   = dump_valid0;
      saw_done = 1'b0;
      cyc      = 0;
      for (int c = 1; c <= 600; c++) begin
         tick;
         start0 = 1'b0;
         if (c == 1) lat_v1 = dump_valid0;
         if (done0) begin
            cyc = c;
            saw_done = 1'b1;
            break;
         end
         ready0 = (mode >= 2) ? 1'($urandom_range(0, 1)) : 1'b1;
         if (mode == 1 && dump_valid0 && dump_addr0 == 5'd7 && hold < 5) begin
            check("bp_valid", 64'(dump_valid0), 64'd1);
            check("bp_word", 64'({dump_addr0, dump_data0}), 64'({5'd7, rf[7]}));
            ready0 = 1'b0;
            hold++;
         end
         if (mode == 3 && dump_valid0 && dump_addr0 == 5'd3 && !hooked) begin
            hooked = 1'b1;
            start0 = 1'b1;
            @(negedge clk);
            rf[4] = 32'hCAFE;
            @(posedge clk);
            #1;
            start0 = 1'b0;
            check("restart_busy", 64'(busy0), 64'd1);
         end
      end
      ready0 = 1'b1;
   endtask

   int cyc;
   bit sd;
   bit any_done;

   initial begin
      rst_n  = 1'b0;
      start0 = 0; abort0 = 0; ready0 = 0;
      start1 = 0; abort1 = 0; ready1 = 0;
      start2 = 0; abort2 = 0; ready2 = 0;
      for (int i = 0; i < 32; i++) rf[i] = '0;
      tick; tick;

      // reset state
      check("rst_rd_addr", 64'(rd_addr0), 64'd0);
      check("rst_valid", 64'(dump_valid0), 64'd0);
      check("rst_busy", 64'(busy0), 64'd0);
      check("rst_done", 64'(done0), 64'd0);
      check("rst_count", 64'(sent_count0), 64'd0);
      rst_n = 1'b1;
      tick;

      // 1: r[i]=i*3, ready always high
      for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3);
      build_exp(0, 31, 0);
      run0(0, cyc, sd);
      check("t1_lat_addr", 64'(lat_addr), 64'd0);
      check("t1_lat_v0", 64'(lat_v0), 64'd0);
      check("t1_lat_v1", 64'(lat_v1), 64'd1);
      check("t1_done_seen", 64'(sd), 64'd1);
      check("t1_done_cycle", 64'(cyc), 64'(exp_cycles));
      check("t1_busy_in_done", 64'(busy0), 64'd1);
      cmp_stream("t1", rx0);
      check("t1_count", 64'(sent_count0), 64'd32);
      tick;
      check("t1_done_pulse", 64'(done0), 64'd0);
      check("t1_busy_after", 64'(busy0), 64'd0);
      check("t1_count_held", 64'(sent_count0), 64'd32);

      // start and abort together in IDLE
      start0 = 1'b1; abort0 = 1'b1;
      tick;
      start0 = 1'b0; abort0 = 1'b0;
      check("sa_busy", 64'(busy0), 64'd0);
      tick;
      check("sa_valid", 64'(dump_valid0), 64'd0);

      // 2: backpressure on word 7, random data
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      build_exp(0, 31, 0);
      run0(1, cyc, sd);
      check("t2_done_seen", 64'(sd), 64'd1);
      check("t2_done_cycle", 64'(cyc), 64'(exp_cycles + 5));
      cmp_stream("t2", rx0);
      check("t2_count", 64'(sent_count0), 64'd32);
      tick;

      // 3: SKIP_ZERO with two nonzero registers
      for (int i = 0; i < 32; i++) rf[i] = '0;
      rf[5] = 32'hDEAD;
      rf[31] = 32'h1;
      build_exp(0, 31, 1);
      rx1.delete();
      start1 = 1'b1; ready1 = 1'b1;
      tick;
      start1 = 1'b0;
      cyc = 0;
      for (int c = 1; c <= 200; c++) begin
         tick;
         if (done1) begin cyc = c; break; end
      end
      check("t3_done_cycle", 64'(cyc), 64'(exp_cycles));
      cmp_stream("t3", rx1);
      check("t3_count", 64'(sent_count1), 64'd2);
      tick;

      // FIRST_ADDR == LAST_ADDR
      rf[7] = $urandom;
      build_exp(7, 7, 0);
      rx2.delete();
      start2 = 1'b1; ready2 = 1'b1;
      tick;
      start2 = 1'b0;
      cyc = 0;
      for (int c = 1; c <= 50; c++) begin
         tick;
         if (done2) begin cyc = c; break; end
      end
      check("one_done_cycle", 64'(cyc), 64'(exp_cycles));
      cmp_stream("one", rx2);
      check("one_count", 64'(sent_count2), 64'd1);
      tick;

      // 4: abort during SEND of word 10, then redump
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      rx0.delete();
      start0 = 1'b1; ready0 = 1'b1;
      tick;
      start0 = 1'b0;
      sd = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (dump_valid0 && dump_addr0 == 5'd10) begin sd = 1'b1; break; end
         tick;
      end
      check("t4_reached", 64'(sd), 64'd1);
      ready0 = 1'b0; abort0 = 1'b1;
      tick;
      abort0 = 1'b0;
      check("t4_valid", 64'(dump_valid0), 64'd0);
      check("t4_busy", 64'(busy0), 64'd0);
      check("t4_count", 64'(sent_count0), 64'd10);
      check("t4_rx", 64'(rx0.size()), 64'd10);
      any_done = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (done0) any_done = 1'b1;
         tick;
      end
      check("t4_no_done", 64'(any_done), 64'd0);
      build_exp(0, 31, 0);
      run0(2, cyc, sd);
      check("t4_redone", 64'(sd), 64'd1);
      cmp_stream("t4_redump", rx0);
      check("t4_recount", 64'(sent_count0), 64'd32);
      tick;

      // 5: restart attempt at word 3 plus write to r4 before its read
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      build_exp(0, 31, 0);
      expq[4] = {5'd4, 32'hCAFE};
      run0(3, cyc, sd);
      check("t5_done", 64'(sd), 64'd1);
      cmp_stream("t5", rx0);
      check("t5_count", 64'(sent_count0), 64'd32);
      tick;

      // 6: reset asserted during SEND
      start0 = 1'b1; ready0 = 1'b1;
      tick;
      start0 = 1'b0;
      sd = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (dump_valid0 && dump_addr0 == 5'd12) begin sd = 1'b1; break; end
         tick;
      end
      check("t6_reached", 64'(sd), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_valid", 64'(dump_valid0), 64'd0);
      check("t6_busy", 64'(busy0), 64'd0);
      check("t6_done", 64'(done0), 64'd0);
      check("t6_rd_addr", 64'(rd_addr0), 64'd0);
      check("t6_count", 64'(sent_count0), 64'd0);
      check("t6_dump_word", 64'({dump_addr0, dump_data0}), 64'd0);
      tick;
      tick;
      rst_n = 1'b1;
      tick;
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      build_exp(0, 31, 0);
      run0(2, cyc, sd);
      check("t6_redone", 64'(sd), 64'd1);
      cmp_stream("t6_redump", rx0);
      check("t6_recount", 64'(sent_count0), 64'd32);
      tick;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
